// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU-side memory access master.
// WRITE_VERIFY_EN adds the read-back verify states to the state enum.
package cpu_mem_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_SIZE = 8;
    localparam int LEN_SIZE  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
`ifdef WRITE_VERIFY_EN
        WR,
        VFY_ISSUE,
        VFY_CHK
`else
        WR
`endif
    } mem_master_state_t;

    typedef struct packed {
        logic                 write;
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
        logic [LEN_SIZE-1:0]  len;
    } mem_req_t;

endpackage

// File: rtl/mem_access_master.sv
// mem_access_master: core-side initiator for a single-port sync memory.
// Accepts single-word writes and 1..2**LEN_SIZE beat read bursts over
// req_valid/req_ready, drives mem_address/mem_write/mem_data_in and
// returns data on rsp_valid/rsp_rdata/rsp_last (rsp_err on verify fail).
// Macro WRITE_VERIFY_EN: re-read each write and flag mismatches.
module mem_access_master
    import cpu_mem_pkg::*;
#(
    parameter int WORD_W = WORD_SIZE,
    parameter int ADDR_W = ADDR_SIZE,
    parameter int LEN_W  = LEN_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_data_in,
    input  logic [WORD_W-1:0] mem_data_out
);

    mem_master_state_t state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              ready_q, ready_d;
    logic              wr_q, wr_d;
    logic              rvld_q, rvld_d;
    logic              rlast_q, rlast_d;
    logic              rerr_q, rerr_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            wr_q    <= 1'b0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        ready_d = ready_q;
        wr_d    = 1'b0;

        // pend_q marks a memory read whose data lands on mem_data_out
        // this cycle; it is turned into a response one edge later.
        rvld_d  = pend_q;
        rdata_d = pend_q ? mem_data_out : rdata_q;
        // Only the last read beat is pending while in RD_DRAIN.
        rlast_d = pend_q && (req_q.write || state_q == RD_DRAIN);
`ifdef WRITE_VERIFY_EN
        rerr_d  = pend_q && (state_q == VFY_CHK)
                  && (mem_data_out != req_q.wdata);
`else
        rerr_d  = 1'b0;
`endif

        // Ready comes back the cycle after the final beat is shown.
        if (rvld_q && rlast_q) begin
            ready_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    ready_d     = 1'b0;
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.len   = req_len;
                    cnt_d       = '0;
                    if (req_write) begin
                        // wdata only updated by writes so mem_data_in
                        // keeps its last value across reads.
                        req_d.wdata = req_wdata;
                        wr_d        = 1'b1;
                        state_d     = WR;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                pend_d = 1'b1;
                if (cnt_q == req_q.len) begin
                    state_d = RD_DRAIN;
                end else begin
                    req_d.addr = req_q.addr + 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            RD_DRAIN: begin
                state_d = IDLE;
            end
`ifdef WRITE_VERIFY_EN
            WR: begin
                state_d = VFY_ISSUE;
            end
            VFY_ISSUE: begin
                pend_d  = 1'b1;
                state_d = VFY_CHK;
            end
            VFY_CHK: begin
                state_d = IDLE;
            end
`else
            WR: begin
                // Memory is read-before-write: the old word is returned.
                pend_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rvld_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_last    = rlast_q;
    assign rsp_err     = rerr_q;
    assign mem_address = req_q.addr;
    assign mem_data_in = req_q.wdata;
    // An in-flight write is suppressed as soon as reset is asserted,
    // so a reset during WR leaves memory untouched.
    assign mem_write   = wr_q & rst_n;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a read-before-write memory.
// Build with +define+WRITE_VERIFY_EN to exercise the verify path.
module tb_mem_access_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] req_len;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_last;
    logic       rsp_err;
    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       clr;
    logic       flip_en;
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_len      (req_len),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_last     (rsp_last),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Sync-read, read-before-write memory; flip_en corrupts bit 0 on read.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            mem_data_out <= mem[mem_address] ^ {7'b0, flip_en};
            if (mem_write) mem[mem_address] <= mem_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Present a request while idle; returns at E0 + 1.
    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [3:0] len);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_len   = len;
        req_valid = 1'b1;
        chk("acc_ready", 32'(req_ready), 32'(1));
        tick();
        req_valid = 1'b0;
    endtask

    // Called at E0 + 1 of a read burst.
    task automatic rd_check(input logic [7:0] a, input logic [3:0] len,
                            input bit busy);
        int n;
        int beat;
        n = int'(len) + 1;
        for (int c = 0; c <= n + 1; c++) begin
            if (c > 0) tick();
            if (c < n) chk("rd_addr", 32'(mem_address), 32'(8'(a + c)));
            if (c < 2) begin
                chk("rd_early", 32'(rsp_valid), 32'(0));
            end else begin
                beat = c - 2;
                chk("rd_vld", 32'(rsp_valid), 32'(1));
                chk("rd_data", 32'(rsp_rdata), 32'(ref_mem[8'(a + beat)]));
                chk("rd_last", 32'(rsp_last), 32'(beat == n - 1));
                chk("rd_err", 32'(rsp_err), 32'(0));
            end
            chk("rd_busy", 32'(req_ready), 32'(0));
            if (busy) chk("busy_nowr", 32'(mem_write), 32'(0));
        end
        tick();
        chk("rd_ready", 32'(req_ready), 32'(1));
        chk("rd_quiet", 32'(rsp_valid), 32'(0));
    endtask

    // Called at E0 + 1 of a write.
    task automatic wr_check(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] old, input logic flip);
        chk("wr_we", 32'(mem_write), 32'(1));
        chk("wr_addr", 32'(mem_address), 32'(a));
        chk("wr_din", 32'(mem_data_in), 32'(d));
        chk("wr_busy", 32'(req_ready), 32'(0));
        tick();
        chk("wr_we_off", 32'(mem_write), 32'(0));
        chk("wr_early", 32'(rsp_valid), 32'(0));
        tick();
`ifdef WRITE_VERIFY_EN
        chk("vfy_early", 32'(rsp_valid), 32'(0));
        tick();
        chk("vfy_vld", 32'(rsp_valid), 32'(1));
        chk("vfy_last", 32'(rsp_last), 32'(1));
        chk("vfy_data", 32'(rsp_rdata), 32'(d ^ {7'b0, flip}));
        chk("vfy_err", 32'(rsp_err), 32'(flip));
`else
        chk("wr_vld", 32'(rsp_valid), 32'(1));
        chk("wr_last", 32'(rsp_last), 32'(1));
        chk("wr_old", 32'(rsp_rdata), 32'(old));
        chk("wr_err", 32'(rsp_err), 32'(0));
        chk("wr_flip", 32'(flip), 32'(0));
`endif
        chk("wr_busy2", 32'(req_ready), 32'(0));
        tick();
        chk("wr_ready", 32'(req_ready), 32'(1));
        chk("wr_quiet", 32'(rsp_valid), 32'(0));
        ref_mem[a] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b1;
        flip_en   = 1'b0;
        pl_en     = 1'b0;
        pl_addr   = 8'h00;
        pl_data   = 8'h00;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        req_len   = 4'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) tick();
        clr = 1'b0;

        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_vld", 32'(rsp_valid), 32'(0));
        chk("rst_last", 32'(rsp_last), 32'(0));
        chk("rst_err", 32'(rsp_err), 32'(0));
        chk("rst_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_addr", 32'(mem_address), 32'(0));
        chk("rst_we", 32'(mem_write), 32'(0));
        chk("rst_din", 32'(mem_data_in), 32'(0));
        rst_n = 1'b1;
        tick();

        // 1: write then single read
        issue(1'b1, 8'h10, 8'hA5, 4'h0);
        wr_check(8'h10, 8'hA5, 8'h00, 1'b0);
        issue(1'b0, 8'h10, 8'h00, 4'h0);
        rd_check(8'h10, 4'h0, 1'b0);
        chk("rd_keep_din", 32'(mem_data_in), 32'(8'hA5));

        // 2: four-beat burst
        preload(8'h00, 8'h11);
        preload(8'h01, 8'h22);
        preload(8'h02, 8'h33);
        preload(8'h03, 8'h44);
        issue(1'b0, 8'h00, 8'h00, 4'h3);
        rd_check(8'h00, 4'h3, 1'b0);

        // 3: burst wrapping FE, FF, 00
        preload(8'hFE, 8'hE1);
        preload(8'hFF, 8'hF2);
        issue(1'b0, 8'hFE, 8'h00, 4'h2);
        rd_check(8'hFE, 4'h2, 1'b0);

        // full-length burst across the top of memory
        for (int i = 0; i < 16; i++) begin
            preload(8'(8'hF8 + i), 8'(8'h50 + 3 * i));
        end
        issue(1'b0, 8'hF8, 8'h00, 4'hF);
        rd_check(8'hF8, 4'hF, 1'b0);

        // 4: request held while busy, accepted once ready returns
        issue(1'b0, 8'h00, 8'h00, 4'h3);
        req_write = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 8'h5A;
        req_len   = 4'h7;
        req_valid = 1'b1;
        rd_check(8'h00, 4'h3, 1'b1);
        tick();
        req_valid = 1'b0;
        wr_check(8'h20, 8'h5A, 8'h00, 1'b0);

        // 5: reset during a write
        preload(8'h30, 8'h3C);
        issue(1'b1, 8'h30, 8'hC3, 4'h0);
        rst_n = 1'b0;
        tick();
        chk("mrst_we", 32'(mem_write), 32'(0));
        chk("mrst_ready", 32'(req_ready), 32'(1));
        chk("mrst_vld", 32'(rsp_valid), 32'(0));
        chk("mrst_addr", 32'(mem_address), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_quiet", 32'(rsp_valid), 32'(0));
            chk("mrst_rdy", 32'(req_ready), 32'(1));
        end
        chk("mrst_mem", 32'(mem[8'h30]), 32'(8'h3C));
        issue(1'b0, 8'h30, 8'h00, 4'h0);
        rd_check(8'h30, 4'h0, 1'b0);

`ifdef WRITE_VERIFY_EN
        // 6: verify with forced read-back fault, then clean
        flip_en = 1'b1;
        issue(1'b1, 8'h40, 8'h66, 4'h0);
        wr_check(8'h40, 8'h66, 8'h00, 1'b1);
        flip_en = 1'b0;
        issue(1'b1, 8'h41, 8'h77, 4'h0);
        wr_check(8'h41, 8'h77, 8'h00, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
